// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO and feeder for uart_tx, clk_uart domain.
// Queued bytes are popped one at a time and held on tx_data for a whole frame.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk_uart,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  input  logic          ovf_clr,
  input  logic          tx_busy,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          idle
);

  localparam logic [AW:0] LvlFull = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWaitBusy, StWaitDone} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW:0]     level_q, level_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      mem [DEPTH];
  logic            push, pop;

  assign full  = (level_q == LvlFull);
  assign empty = (level_q == '0);

  // Full is judged on pre-edge level, so a same-cycle pop never frees a slot for this write.
  assign push = wr_en && !full && !flush;

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty && !flush) begin
          pop        = 1'b1;
          tx_data_d  = mem[rptr_q];
          tx_start_d = 1'b1;
          state_d    = StWaitBusy;
        end
      end
      StWaitBusy: begin
        if (tx_busy) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (!tx_busy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wptr_d  = wptr_q + AW'(push);
    rptr_d  = rptr_q + AW'(pop);
    level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
    if (flush) begin
      rptr_d  = wptr_q;
      level_d = '0;
    end
  end

  // A dropped write during flush is intentional, not an overflow.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_en && full && !flush) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_uart) begin
    if (push) mem[wptr_q] <= wr_data;
  end

  always_ff @(posedge clk_uart or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign level    = level_q;
  assign overflow = ovf_q;
  assign idle     = empty && (state_q == StIdle) && !tx_busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural uart_tx (8N1, 2 clocks per bit)
// and a byte scoreboard: expected bytes queued at write, compared per received frame.
module tb_uart_tx_fifo;

  localparam int BIT_CYC = 2;

  logic       clk_uart = 1'b0;
  logic       rst      = 1'b1;
  logic       wr_en    = 1'b0;
  logic [7:0] wr_data  = 8'h00;
  logic       flush    = 1'b0;
  logic       ovf_clr  = 1'b0;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       full, empty, overflow, idle;
  logic [4:0] level;

  always #5 clk_uart = ~clk_uart;

  uart_tx_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk_uart (clk_uart),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .ovf_clr  (ovf_clr),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .idle     (idle)
  );

  // uart_tx model: reads tx_data bit by bit while the frame is in flight.
  logic       busy     = 1'b0;
  logic       stall    = 1'b0;
  logic       tx_out   = 1'b1;
  logic       unstable = 1'b0;
  logic [7:0] lat      = 8'h00;
  logic [7:0] rx_sh    = 8'h00;
  int         bitn     = 0;
  int         cyc      = 0;
  int         starts   = 0;
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];

  assign tx_busy = busy;

  always @(posedge clk_uart or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      bitn   <= 0;
      cyc    <= 0;
      tx_out <= 1'b1;
    end else if (!busy) begin
      if (tx_start) begin
        busy   <= 1'b1;
        bitn   <= 0;
        cyc    <= 0;
        tx_out <= 1'b0;
        lat    <= tx_data;
        starts <= starts + 1;
      end
    end else begin
      if (tx_data != lat) unstable <= 1'b1;
      if (cyc < BIT_CYC - 1) begin
        cyc <= cyc + 1;
      end else if (bitn < 9) begin
        cyc  <= 0;
        bitn <= bitn + 1;
        if (bitn < 8) begin
          tx_out <= tx_data[bitn];
          rx_sh  <= {tx_data[bitn], rx_sh[7:1]};
        end else begin
          tx_out <= 1'b1;
        end
      end else if (!stall) begin
        busy <= 1'b0;
        rx_q.push_back(rx_sh);
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic step();
    @(posedge clk_uart);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b, input bit accept);
    wr_en   = 1'b1;
    wr_data = b;
    step();
    wr_en   = 1'b0;
    if (accept) exp_q.push_back(b);
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      int n = 0;
      while (rx_q.size() == 0 && n < 400) begin
        step();
        n++;
      end
      chk({tag, "_frame_seen"}, 32'(rx_q.size() > 0), 1);
      if (rx_q.size() == 0) begin
        exp_q.delete();
        return;
      end
      chk(tag, 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!idle && n < 400) begin
      step();
      n++;
    end
    chk(tag, 32'(idle), 1);
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (!tx_busy && n < 50) begin
      step();
      n++;
    end
    chk(tag, 32'(tx_busy), 1);
  endtask

  initial begin
    int s0;
    int n;

    repeat (3) @(posedge clk_uart);
    #1 rst = 1'b0;
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_idle", 32'(idle), 1);

    // Single byte and start latency.
    s0 = starts;
    wr(8'hA5, 1'b1);
    chk("lat_n_start", 32'(tx_start), 0);
    chk("lat_n_level", 32'(level), 1);
    step();
    chk("lat_n1_start", 32'(tx_start), 1);
    chk("lat_n1_data", 32'(tx_data), 32'hA5);
    chk("lat_n1_level", 32'(level), 0);
    step();
    chk("lat_n2_start", 32'(tx_start), 0);
    chk("lat_n2_busy", 32'(tx_busy), 1);
    drain("single_byte");
    wait_idle("single_idle");
    chk("single_starts", 32'(starts - s0), 1);

    // Burst behind a stalled frame, then overflow.
    wr(8'h00, 1'b1);
    wait_busy("burst_busy");
    stall = 1'b1;
    for (int i = 1; i <= 16; i++) wr(8'(i), 1'b1);
    chk("burst_full", 32'(full), 1);
    chk("burst_level", 32'(level), 16);
    chk("burst_ovf_pre", 32'(overflow), 0);
    wr(8'h11, 1'b0);
    chk("burst_ovf", 32'(overflow), 1);
    chk("burst_level_keep", 32'(level), 16);
    wr_en   = 1'b1;
    ovf_clr = 1'b1;
    step();
    wr_en   = 1'b0;
    ovf_clr = 1'b0;
    chk("ovf_set_beats_clr", 32'(overflow), 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 0);

    // Full corner: write lands on the same edge as the pop.
    stall = 1'b0;
    n = 0;
    while (tx_busy && n < 50) begin
      step();
      n++;
    end
    chk("corner_busy_fall", 32'(tx_busy), 0);
    step();
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    step();
    wr_en   = 1'b0;
    chk("corner_pop", 32'(tx_start), 1);
    chk("corner_data", 32'(tx_data), 32'h01);
    chk("corner_level", 32'(level), 15);
    chk("corner_ovf", 32'(overflow), 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("corner_ovf_clr", 32'(overflow), 0);
    drain("burst_order");
    wait_idle("burst_idle");

    // Flush while a frame is in flight.
    s0 = starts;
    wr(8'h20, 1'b1);
    wait_busy("flush_busy");
    for (int i = 0; i < 5; i++) wr(8'(8'h21 + i), 1'b0);
    chk("flush_level_pre", 32'(level), 5);
    flush   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h26;
    step();
    flush   = 1'b0;
    wr_en   = 1'b0;
    chk("flush_level", 32'(level), 0);
    chk("flush_empty", 32'(empty), 1);
    chk("flush_no_ovf", 32'(overflow), 0);
    drain("flush_frame");
    wait_idle("flush_idle");
    chk("flush_starts", 32'(starts - s0), 1);

    // Pointer wrap with paced writes.
    s0 = starts;
    for (int i = 0; i < 40; i++) begin
      n = 0;
      while (level >= 3 && n < 200) begin
        step();
        n++;
      end
      wr(8'(8'h40 + i), 1'b1);
    end
    drain("wrap_order");
    wait_idle("wrap_idle");
    chk("wrap_starts", 32'(starts - s0), 40);

    // Reset in the middle of a frame.
    s0 = starts;
    wr(8'h77, 1'b1);
    wait_busy("midrst_busy");
    repeat (3) step();
    wr(8'h78, 1'b1);
    wr(8'h79, 1'b1);
    rst = 1'b1;
    #2;
    chk("midrst_start", 32'(tx_start), 0);
    chk("midrst_data", 32'(tx_data), 32'h00);
    chk("midrst_level", 32'(level), 0);
    rst = 1'b0;
    exp_q.delete();
    repeat (60) step();
    chk("midrst_no_start", 32'(starts - s0), 1);
    chk("midrst_no_frame", 32'(rx_q.size()), 0);
    chk("midrst_idle", 32'(idle), 1);

    chk("tx_data_stable", 32'(unstable), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
